rf_forest_engine: RTL and testbench
===================================

Name: rf_forest_engine

Overview:
- Parametrised random-forest classifier core. Successor to the single-forest, binary-label, real-valued top.
- Evaluates NUM_TREES complete binary trees on a signed fixed-point feature vector, one node comparison per cycle, one tree at a time.
- Majority-votes over NUM_CLASSES labels.
- Tree contents (feature index, threshold, leaf label) are loaded at run time through a config write port, so one netlist serves any trained model of matching shape.

Parameters:
- NUM_TREES, 5, number of trees in the forest
- TREE_DEPTH, 4, comparisons per tree; each tree has 2^TREE_DEPTH-1 internal nodes and 2^TREE_DEPTH leaves
- NUM_FEATURES, 11, features per datapoint
- FEAT_W, 16, feature/threshold width, signed two's complement
- NUM_CLASSES, 2, number of output classes
- Derived widths:
  - TREE_W = max(1, clog2(NUM_TREES))
  - FIDX_W = max(1, clog2(NUM_FEATURES))
  - CLASS_W = max(1, clog2(NUM_CLASSES))
  - VOTE_W = clog2(NUM_TREES+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_traversal  in  1  start request, sampled in IDLE only
- features  in  NUM_FEATURES*FEAT_W  flat vector, feature i at [i*FEAT_W +: FEAT_W]
- cfg_we  in  1  config write strobe
- cfg_leaf  in  1  0 = internal-node write, 1 = leaf write
- cfg_tree  in  TREE_W  target tree
- cfg_addr  in  TREE_DEPTH  node index (internal 0..2^D-2) or leaf index (0..2^D-1)
- cfg_feat  in  FIDX_W  feature index for internal node
- cfg_thresh  in  FEAT_W  signed threshold for internal node
- cfg_label  in  CLASS_W  class for leaf
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, result valid
- final_label  out  CLASS_W  winning class, held until next done

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state=IDLE; busy=0, done=0, final_label=0; vote counters, tree counter and level counter cleared.
  - Node/leaf memories are not cleared; they keep their contents across reset and are undefined after power-up.
- IDLE:
  - start_traversal=1 → capture features into an internal register, busy=1, tree=0, node=0, level=0 → WALK.
  - cfg_we=1 writes the selected memory entry; cfg_tree outside 0..NUM_TREES-1 or an out-of-range cfg_addr is ignored.
- WALK (one cycle per level):
  - Compare feature[node.feat] with node.thresh, signed. Less-or-equal → node=2*node+1, otherwise → node=2*node+2.
  - A node.feat ≥ NUM_FEATURES compares the value 0.
  - After TREE_DEPTH comparisons → LEAF.
- LEAF (1 cycle):
  - leaf index = node-(2^TREE_DEPTH-1); votes[label]++ using a saturating VOTE_W counter. A label ≥ NUM_CLASSES casts no vote.
  - If tree==NUM_TREES-1 → DECIDE; otherwise tree++, node=0, level=0 → WALK.
- DECIDE (1 cycle):
  - argmax over vote counters; on a tie the lowest class index wins.
  - Register final_label, done=1, busy=0 → IDLE.
- done is high for exactly one cycle. Latency from the edge that samples start to the edge that raises done is NUM_TREES*(TREE_DEPTH+1)+1 cycles (26 at defaults).
- While busy:
  - start_traversal is ignored.
  - cfg_we is ignored (the write is dropped, never deferred).
  - The features input may change freely; only the captured copy is used.
- Start in the same cycle done is high: accepted, since the state is already IDLE in the following cycle.
- Reset mid-operation: immediate return to IDLE, no done pulse, votes discarded, final_label=0.

Optional Feature:
- Macro RF_FOREST_VOTES_EN.
- Defined: adds output port win_votes [VOTE_W-1:0] = vote count of the winning class. It is registered with final_label, cleared to 0 by reset, and held until the next done.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults, reset asserted 2 cycles → busy=0, done=0, final_label=0; start asserted during reset is not accepted.
- All internal nodes of all trees set to feat=0, thresh=100; leaf0=1 and leaf15=0 in every tree:
  - features[0]=50 → done 26 cycles after start, final_label=1
  - features[0]=100 → final_label=1 (equal goes left)
  - features[0]=101 → final_label=0
- Same config, but trees 3–4 have leaf0=0, features[0]=50 → final_label=1, win_votes=3 (macro on).
- NUM_CLASSES=4, trees 0–1 leaf0=3, trees 2–3 leaf0=2, tree 4 leaf0=0 → final_label=2 (tie resolved to lower index).
- Signed compare: thresh=-5; feature=-6 → left path, feature=-4 → right path; feature index 12 → compares 0, which goes right against thresh=-5.
- Second start and a cfg write issued at cycle 5 of a run → both ignored, original result unchanged. Reset at cycle 10 → busy=0 next cycle and no done pulse. A fresh start then completes normally in 26 cycles.

Source files
------------

// File: rtl/rf_forest_engine.sv
// Random-forest classifier core: walks run-time-loaded binary trees, one node per cycle, then majority-votes.
// Optional macro RF_FOREST_VOTES_EN adds the win_votes output (vote count of the winning class).
module rf_forest_engine #(
  parameter int unsigned NUM_TREES    = 5,
  parameter int unsigned TREE_DEPTH   = 4,
  parameter int unsigned NUM_FEATURES = 11,
  parameter int unsigned FEAT_W       = 16,
  parameter int unsigned NUM_CLASSES  = 2,
  localparam int unsigned TREE_W  = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1,
  localparam int unsigned FIDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int unsigned CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned VOTE_W  = $clog2(NUM_TREES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_traversal,
  input  logic [NUM_FEATURES*FEAT_W-1:0]   features,
  input  logic                             cfg_we,
  input  logic                             cfg_leaf,
  input  logic [TREE_W-1:0]                cfg_tree,
  input  logic [TREE_DEPTH-1:0]            cfg_addr,
  input  logic [FIDX_W-1:0]                cfg_feat,
  input  logic [FEAT_W-1:0]                cfg_thresh,
  input  logic [CLASS_W-1:0]               cfg_label,
  output logic                             busy,
  output logic                             done,
`ifdef RF_FOREST_VOTES_EN
  output logic [VOTE_W-1:0]                win_votes,
`endif
  output logic [CLASS_W-1:0]               final_label
);

  localparam int unsigned NUM_NODES  = (1 << TREE_DEPTH) - 1;
  localparam int unsigned NUM_LEAVES = 1 << TREE_DEPTH;
  localparam int unsigned NODE_W     = TREE_DEPTH + 1;
  localparam int unsigned LEVEL_W    = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WALK, LEAF, DECIDE} state_t;

  state_t                          state;
  logic [TREE_W-1:0]               tree;
  logic [NODE_W-1:0]               node;
  logic [LEVEL_W-1:0]              level;
  logic [NUM_FEATURES*FEAT_W-1:0]  feat_q;
  logic [VOTE_W-1:0]               votes [NUM_CLASSES];

  logic [FIDX_W-1:0]               node_feat_mem   [NUM_TREES][NUM_NODES];
  logic [FEAT_W-1:0]               node_thresh_mem [NUM_TREES][NUM_NODES];
  logic [CLASS_W-1:0]              leaf_label_mem  [NUM_TREES][NUM_LEAVES];

  logic [FIDX_W-1:0]               cur_fidx;
  logic signed [FEAT_W-1:0]        cur_feat;
  logic signed [FEAT_W-1:0]        cur_thresh;
  logic                            go_left;
  logic [NODE_W-1:0]               next_node;
  logic [TREE_DEPTH-1:0]           leaf_idx;
  logic [CLASS_W-1:0]              leaf_label;
  logic                            leaf_valid;
  logic [CLASS_W-1:0]              best_class;
  logic [VOTE_W-1:0]               best_votes;

  // Config port: writes land only while idle and only for in-range entries
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we && 32'(cfg_tree) < NUM_TREES) begin
      if (cfg_leaf) begin
        leaf_label_mem[cfg_tree][cfg_addr] <= cfg_label;
      end else if (32'(cfg_addr) < NUM_NODES) begin
        node_feat_mem[cfg_tree][cfg_addr]   <= cfg_feat;
        node_thresh_mem[cfg_tree][cfg_addr] <= cfg_thresh;
      end
    end
  end

  // Current node compare; an out-of-range feature index reads as zero
  always_comb begin
    cur_fidx   = node_feat_mem[tree][node[TREE_DEPTH-1:0]];
    cur_thresh = node_thresh_mem[tree][node[TREE_DEPTH-1:0]];
    cur_feat   = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (cur_fidx == FIDX_W'(i)) cur_feat = feat_q[i*FEAT_W +: FEAT_W];
    end
    go_left   = (cur_feat <= cur_thresh);
    next_node = {node[NODE_W-2:0], 1'b0} + (go_left ? NODE_W'(1) : NODE_W'(2));
  end

  always_comb begin
    leaf_idx   = TREE_DEPTH'(node - NODE_W'(NUM_NODES));
    leaf_label = leaf_label_mem[tree][leaf_idx];
    leaf_valid = (32'(leaf_label) < NUM_CLASSES);
  end

  // Argmax with strict greater-than so ties keep the lowest class index
  always_comb begin
    best_class = '0;
    best_votes = votes[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (votes[c] > best_votes) begin
        best_class = CLASS_W'(c);
        best_votes = votes[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      final_label <= '0;
      tree        <= '0;
      node        <= '0;
      level       <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) votes[c] <= '0;
`ifdef RF_FOREST_VOTES_EN
      win_votes   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_traversal) begin
            feat_q <= features;
            busy   <= 1'b1;
            tree   <= '0;
            node   <= '0;
            level  <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) votes[c] <= '0;
            state  <= WALK;
          end
        end
        WALK: begin
          node <= next_node;
          if (level == LEVEL_W'(TREE_DEPTH - 1)) begin
            level <= '0;
            state <= LEAF;
          end else begin
            level <= level + LEVEL_W'(1);
          end
        end
        LEAF: begin
          if (leaf_valid && votes[leaf_label] != '1) begin
            votes[leaf_label] <= votes[leaf_label] + VOTE_W'(1);
          end
          if (tree == TREE_W'(NUM_TREES - 1)) begin
            state <= DECIDE;
          end else begin
            tree  <= tree + TREE_W'(1);
            node  <= '0;
            level <= '0;
            state <= WALK;
          end
        end
        DECIDE: begin
          final_label <= best_class;
`ifdef RF_FOREST_VOTES_EN
          win_votes   <= best_votes;
`endif
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_forest_engine.sv
// Scoreboard bench for rf_forest_engine: directed runs push expectations, a monitor checks each done pulse.
module tb_rf_forest_engine;

  localparam int unsigned NT = 5;
  localparam int unsigned TD = 4;
  localparam int unsigned NF = 11;
  localparam int unsigned FW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned LAT = 26;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_traversal = 1'b0;
  logic [NF*FW-1:0]  features = '0;
  logic              cfg_we = 1'b0;
  logic              cfg_leaf = 1'b0;
  logic [2:0]        cfg_tree = '0;
  logic [3:0]        cfg_addr = '0;
  logic [3:0]        cfg_feat = '0;
  logic [15:0]       cfg_thresh = '0;
  logic [1:0]        cfg_label = '0;
  logic              busy;
  logic              done;
  logic [1:0]        final_label;
`ifdef RF_FOREST_VOTES_EN
  logic [2:0]        win_votes;
`endif

  rf_forest_engine #(.NUM_TREES(NT), .TREE_DEPTH(TD), .NUM_FEATURES(NF),
                     .FEAT_W(FW), .NUM_CLASSES(NC)) dut (
    .clk(clk), .reset(reset), .start_traversal(start_traversal), .features(features),
    .cfg_we(cfg_we), .cfg_leaf(cfg_leaf), .cfg_tree(cfg_tree), .cfg_addr(cfg_addr),
    .cfg_feat(cfg_feat), .cfg_thresh(cfg_thresh), .cfg_label(cfg_label),
    .busy(busy), .done(done),
`ifdef RF_FOREST_VOTES_EN
    .win_votes(win_votes),
`endif
    .final_label(final_label)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] label;
    logic [2:0] votes;
    int         start_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      nchk++;
      if (prev_done || busy) begin
        nfail++;
        $display("FAIL done_shape: prev_done=%0b busy=%0b, required 0/0", prev_done, busy);
      end
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_done: done at cycle %0d with no run outstanding", cyc);
      end else begin
        e = q.pop_front();
        if (final_label !== e.label) begin
          nfail++;
          $display("FAIL final_label: got %0d, required %0d", final_label, e.label);
        end
        nchk++;
        if (cyc - e.start_cyc != LAT) begin
          nfail++;
          $display("FAIL latency: got %0d, required %0d", cyc - e.start_cyc, LAT);
        end
`ifdef RF_FOREST_VOTES_EN
        nchk++;
        if (win_votes !== e.votes) begin
          nfail++;
          $display("FAIL win_votes: got %0d, required %0d", win_votes, e.votes);
        end
`endif
      end
    end
    prev_done = done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic wr(input logic leaf, input int tree, input int addr,
                    input int feat, input int thresh, input int label);
    cfg_leaf = leaf; cfg_tree = 3'(tree); cfg_addr = 4'(addr);
    cfg_feat = 4'(feat); cfg_thresh = 16'(thresh); cfg_label = 2'(label);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_uniform(input int feat, input int thresh, input int l0, input int l15);
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < 15; n++) wr(1'b0, t, n, feat, thresh, 0);
      wr(1'b1, t, 0, 0, 0, l0);
      wr(1'b1, t, 15, 0, 0, l15);
    end
  endtask

  task automatic start_run(input int f0, input int lbl, input int votes);
    exp_t e;
    features = '0;
    features[FW-1:0] = 16'(f0);
    start_traversal = 1'b1;
    e.label = 2'(lbl); e.votes = 3'(votes); e.start_cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start_traversal = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (n >= 100) begin
      nfail++;
      $display("FAIL timeout: run still outstanding after %0d cycles", n);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with start asserted; start must not be taken
    start_traversal = 1'b1;
    features[FW-1:0] = 16'd50;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_label", 32'(final_label), 32'd0);
    reset = 1'b0;
    start_traversal = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    cfg_uniform(0, 100, 1, 0);
    start_run(50, 1, 5);   wait_idle();
    start_run(100, 1, 5);  wait_idle();
    start_run(101, 0, 5);  wait_idle();

    wr(1'b1, 3, 0, 0, 0, 0);
    wr(1'b1, 4, 0, 0, 0, 0);
    start_run(50, 1, 3);   wait_idle();

    // Second start plus a config write at cycle 5 of a run: both dropped
    start_run(50, 1, 3);
    repeat (4) @(negedge clk);
    features[FW-1:0] = 16'd101;
    start_traversal = 1'b1;
    wr(1'b1, 2, 0, 0, 0, 0);
    start_traversal = 1'b0;
    wait_idle();
    start_run(50, 1, 3);   wait_idle();

    // Reset at cycle 10 of a run: no done, label cleared
    start_run(50, 1, 3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_label", 32'(final_label), 32'd0);
    repeat (40) @(negedge clk);
    check("midreset_still_idle", 32'(busy), 32'd0);
    start_run(50, 1, 3);   wait_idle();

    // Signed thresholds and out-of-range feature index
    cfg_uniform(0, -5, 1, 0);
    start_run(-6, 1, 5);   wait_idle();
    start_run(-4, 0, 5);   wait_idle();
    start_run(-5, 1, 5);   wait_idle();
    cfg_uniform(12, -5, 1, 0);
    start_run(-6, 0, 5);   wait_idle();

    // Four classes: 3 and 2 tie on two votes, lower index wins
    cfg_uniform(0, 100, 0, 0);
    wr(1'b1, 0, 0, 0, 0, 3);
    wr(1'b1, 1, 0, 0, 0, 3);
    wr(1'b1, 2, 0, 0, 0, 2);
    wr(1'b1, 3, 0, 0, 0, 2);
    start_run(50, 2, 2);   wait_idle();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
